// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, divider calculation and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_WAIT_HIGH
  } uart_rx_state_t;

  function automatic int calc_div(input int sys_clk, input int baud_rate, input int oversample);
    return sys_clk / (baud_rate * oversample);
  endfunction

  // Callers zero-extend narrower words, so unused upper bits do not affect the result.
  function automatic logic parity_of(input logic [8:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word output bundle with valid/ready handshake and status flags.
interface uart_rx_os_if #(
  parameter int data_width = 8
) ();
  logic [data_width-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  framing_error;
  logic                  parity_error;
  logic                  overrun_error;
  logic                  busy;

  modport master (
    output data_out, data_valid, framing_error, parity_error, overrun_error, busy,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, framing_error, parity_error, overrun_error, busy,
    output data_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..div-1 while enabled, one-cycle os_tick at div-1.
module uart_baud_tick #(
  parameter int div = 65
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic os_tick
);
  localparam int cw = $clog2(div);

  logic [cw-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr || !en) cnt <= '0;
    else if (cnt == cw'(div - 1)) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign os_tick = en && !clr && (cnt == cw'(div - 1));
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop sync, 3-sample majority vote, valid/ready output.
// Defining UART_RX_BREAK_DET_EN adds the break_det pulse output.
// state     | meaning
// IDLE      | waiting for synced rx falling edge
// START     | validating start bit (false start returns to IDLE)
// DATA      | shifting data bits LSB first
// PARITY    | sampling parity bit
// STOP1     | first stop bit
// STOP2     | second stop bit
// WAIT_HIGH | line still low after frame, wait for idle level
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int sys_clk    = 10_000_000,
  parameter int baud_rate  = 9600,
  parameter int data_width = 8,
  parameter int oversample = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_en,
  input  logic rx,
  input  logic parity_en,
  input  logic odd_r_even_parity,
  input  logic two_stop,
`ifdef UART_RX_BREAK_DET_EN
  output logic break_det,
`endif
  uart_rx_os_if.master bus
);
  localparam int div  = calc_div(sys_clk, baud_rate, oversample);
  localparam int half = oversample / 2;
  localparam int scw  = $clog2(oversample);
  localparam int bcw  = $clog2(data_width);

  if (data_width < 5 || data_width > 9) begin : g_chk_width
    $error("uart_rx_os: data_width must be 5..9");
  end
  if (oversample < 8 || (oversample % 2) != 0) begin : g_chk_os
    $error("uart_rx_os: oversample must be even and >= 8");
  end
  if (div < 2) begin : g_chk_div
    $error("uart_rx_os: clock divider must be >= 2");
  end

  uart_rx_state_t state, state_nx;

  logic sync1, sync2, rx_prev, rx_s, start_edge;
  logic os_tick, tick_en, go_start, commit, decide, bit_end;
  logic [scw-1:0] s_cnt;
  logic [bcw-1:0] bit_cnt;
  logic [data_width-1:0] data_sr, data_q;
  logic samp0, samp1, maj, par_bit, stop1_low;
  logic cfg_par, cfg_odd, cfg_two;
  logic fe_now, pe_now, brk, brk_gate, load;
  logic valid_q, fe_q, pe_q, ov_q;

  always_ff @(posedge clk) begin
    if (!rst) {sync1, sync2, rx_prev} <= 3'b111;
    else {sync1, sync2, rx_prev} <= {rx, sync1, sync2};
  end

  assign rx_s       = sync2;
  assign start_edge = rx_prev && !rx_s;
  assign tick_en    = baud_en && (state != ST_IDLE);

  uart_baud_tick #(.div(div)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (tick_en),
    .clr    (go_start),
    .os_tick(os_tick)
  );

  assign decide  = os_tick && (s_cnt == scw'(half + 1));
  assign bit_end = os_tick && (s_cnt == scw'(oversample - 1));
  assign maj     = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign fe_now  = !maj || ((state == ST_STOP2) && stop1_low);
  assign pe_now  = cfg_par && (par_bit != (parity_of(9'(data_sr)) ^ cfg_odd));
  assign brk     = !(|data_sr) && !(cfg_par && par_bit) &&
                   ((state == ST_STOP1) ? !maj : stop1_low);

  always_comb begin
    state_nx = state;
    go_start = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE:
        if (start_edge) begin
          state_nx = ST_START;
          go_start = 1'b1;
        end
      ST_START:
        if (decide && maj) state_nx = ST_IDLE;
        else if (bit_end) state_nx = ST_DATA;
      ST_DATA:
        if (bit_end && (bit_cnt == bcw'(data_width - 1)))
          state_nx = cfg_par ? ST_PARITY : ST_STOP1;
      ST_PARITY:
        if (bit_end) state_nx = ST_STOP1;
      ST_STOP1:
        if (!cfg_two && decide) begin
          commit   = 1'b1;
          state_nx = (maj && !brk) ? ST_IDLE : ST_WAIT_HIGH;
        end else if (cfg_two && bit_end) begin
          state_nx = ST_STOP2;
        end
      ST_STOP2:
        if (decide) begin
          commit   = 1'b1;
          state_nx = (maj && !brk) ? ST_IDLE : ST_WAIT_HIGH;
        end
      ST_WAIT_HIGH:
        if (rx_s) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // Dropping baud_en abandons any partial frame without touching the output register.
    if (!baud_en) begin
      state_nx = ST_IDLE;
      go_start = 1'b0;
      commit   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_cnt     <= '0;
      bit_cnt   <= '0;
      data_sr   <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      par_bit   <= 1'b0;
      stop1_low <= 1'b0;
      cfg_par   <= 1'b0;
      cfg_odd   <= 1'b0;
      cfg_two   <= 1'b0;
    end else begin
      if (go_start) begin
        s_cnt     <= '0;
        bit_cnt   <= '0;
        stop1_low <= 1'b0;
        cfg_par   <= parity_en;
        cfg_odd   <= odd_r_even_parity;
        cfg_two   <= two_stop;
      end else if (os_tick) begin
        s_cnt <= (s_cnt == scw'(oversample - 1)) ? '0 : s_cnt + 1'b1;
      end
      if (os_tick && (s_cnt == scw'(half - 1))) samp0 <= rx_s;
      if (os_tick && (s_cnt == scw'(half))) samp1 <= rx_s;
      if (decide) begin
        if (state == ST_DATA) data_sr <= {maj, data_sr[data_width-1:1]};
        if (state == ST_PARITY) par_bit <= maj;
        if (state == ST_STOP1) stop1_low <= !maj;
      end
      if (bit_end && (state == ST_DATA)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  assign brk_gate = brk;

  always_ff @(posedge clk) begin
    if (!rst) break_det <= 1'b0;
    else break_det <= commit && brk;
  end
`else
  assign brk_gate = 1'b0;
`endif

  // A commit while the consumer accepts the old word loads the new one in the same cycle.
  assign load = commit && !brk_gate && (!valid_q || bus.data_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else if (load) begin
      data_q  <= data_sr;
      valid_q <= 1'b1;
      fe_q    <= fe_now;
      pe_q    <= pe_now;
      ov_q    <= 1'b0;
    end else if (valid_q && bus.data_ready) begin
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else if (commit && !brk_gate) begin
      ov_q <= 1'b1;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.framing_error = fe_q;
  assign bus.parity_error  = pe_q;
  assign bus.overrun_error = ov_q;
  assign bus.busy          = (state != ST_IDLE);
endmodule
